// File: rtl/phctrl_dump_accum_pkg.sv
// -----------------------------------------------------------------------------
// phctrl_dump_accum_pkg
// Shared helpers for the phase-synchronous integrate-and-dump detector.
// No ports. Exposes ref_is_neg(), which decides the sign of the square-wave
// reference for a given phase.
// -----------------------------------------------------------------------------
package phctrl_dump_accum_pkg;

  // Square-wave reference: phases below `half` multiply by +1, all others by -1.
  // Both operands are taken as unsigned 32-bit values.
  function automatic logic ref_is_neg(input logic [31:0] phase,
                                      input logic [31:0] half);
    return (phase >= half);
  endfunction

endpackage : phctrl_dump_accum_pkg

// File: rtl/phctrl_out_reg.sv
// -----------------------------------------------------------------------------
// phctrl_out_reg
// Holding register for dumped sums, with a valid/ready handshake toward the
// next DDC stage and a one-cycle overrun flag.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load           : a new result is presented on din this cycle
//   din            : result to load
//   ready_i        : downstream accepts dout when valid_o && ready_i
//   dout           : held result
//   valid_o        : dout holds an unconsumed result
//   overrun_o      : an unconsumed result was overwritten (one cycle)
// -----------------------------------------------------------------------------
module phctrl_out_reg #(
  parameter int ACC_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        load,
  input  logic signed [ACC_WIDTH-1:0] din,
  input  logic                        ready_i,
  output logic signed [ACC_WIDTH-1:0] dout,
  output logic                        valid_o,
  output logic                        overrun_o
);

  logic signed [ACC_WIDTH-1:0] dout_q, dout_d;
  logic                        valid_q, valid_d;
  logic                        overrun_q, overrun_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load) begin
      dout_d    = din;
      valid_d   = 1'b1;
      // Overwriting a result nobody is taking this cycle loses it.
      overrun_d = valid_q && !ready_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    if (rst_i) begin
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout      = dout_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule : phctrl_out_reg

// File: rtl/phctrl_dump_accum.sv
// -----------------------------------------------------------------------------
// phctrl_dump_accum
// Integrate-and-dump detector locked to the DDC phase-control counter. Each
// enabled sample is multiplied by a +/-1 square-wave reference derived from
// its phase and accumulated over one full phase period; at each period
// boundary the sum is dumped into a valid/ready output register.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : sample enable (shared with the phase counter)
//   data_i       : signed input sample
//   phase_i      : counter phase, unsigned
//   pulse_i      : period pulse, high on the phase-0 sample
//   acc_o        : signed dumped sum
//   valid_o      : acc_o holds an unconsumed result
//   ready_i      : downstream accept
//   overrun_o    : one-cycle flag, an unconsumed result was overwritten
// -----------------------------------------------------------------------------
module phctrl_dump_accum
  import phctrl_dump_accum_pkg::*;
#(
  parameter int          DIN_WIDTH   = 16,
  parameter int          PHASE_WIDTH = 16,
  parameter int          ACC_WIDTH   = 32,
  parameter int unsigned HALF        = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic signed [DIN_WIDTH-1:0] data_i,
  input  logic [PHASE_WIDTH-1:0]      phase_i,
  input  logic                        pulse_i,
  output logic signed [ACC_WIDTH-1:0] acc_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        overrun_o
);

  // UNPRIMED discards samples until the first period boundary so that the
  // first dumped result always covers a complete period.
  typedef enum logic {
    UNPRIMED = 1'b0,
    RUN      = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] term_ext, term;
  logic                        dump;

  always_comb begin
    // Sign-extend before negating so the most-negative sample negates cleanly.
    term_ext = {{(ACC_WIDTH-DIN_WIDTH){data_i[DIN_WIDTH-1]}}, data_i};
    term     = ref_is_neg(32'(phase_i), 32'(HALF)) ? -term_ext : term_ext;

    state_d = state_q;
    acc_d   = acc_q;
    dump    = 1'b0;
    if (en_i) begin
      case (state_q)
        UNPRIMED: begin
          if (pulse_i) begin
            acc_d   = term;
            state_d = RUN;
          end
        end
        RUN: begin
          if (pulse_i) begin
            // Boundary: the finished period leaves via the output register
            // while the new period starts from this sample's term.
            dump  = 1'b1;
            acc_d = term;
          end else begin
            acc_d = acc_q + term;  // wraps in two's complement
          end
        end
        default: state_d = UNPRIMED;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= UNPRIMED;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  phctrl_out_reg #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_out_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (dump),
    .din       (acc_q),
    .ready_i   (ready_i),
    .dout      (acc_o),
    .valid_o   (valid_o),
    .overrun_o (overrun_o)
  );

endmodule : phctrl_dump_accum

// File: tb/tb_phctrl_dump_accum.sv
// -----------------------------------------------------------------------------
// tb_phctrl_dump_accum
// Drives phctrl_dump_accum from a modelled phase counter (INC=1, UPTO=10) and
// checks it against a period-level reference: each complete period's samples
// are collected and summed with +/-1 weights, results queue up in order, and a
// monitor compares whatever the DUT presents against that queue.
// -----------------------------------------------------------------------------
module tb_phctrl_dump_accum;

  localparam int          DW   = 16;
  localparam int          PW   = 16;
  localparam int          AW   = 32;
  localparam int unsigned HALF = 5;
  localparam int          UPTO = 10;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 en_i;
  logic signed [DW-1:0] data_i;
  logic [PW-1:0]        phase_i;
  logic                 pulse_i;
  logic signed [AW-1:0] acc_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 overrun_o;

  phctrl_dump_accum #(
    .DIN_WIDTH   (DW),
    .PHASE_WIDTH (PW),
    .ACC_WIDTH   (AW),
    .HALF        (HALF)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .data_i    (data_i),
    .phase_i   (phase_i),
    .pulse_i   (pulse_i),
    .acc_o     (acc_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int phase;
    int data;
  } samp_t;

  samp_t                period[$];
  logic signed [AW-1:0] exp_q[$];
  bit                   primed = 1'b0;

  function automatic logic signed [AW-1:0] period_sum();
    longint s = 0;
    foreach (period[i])
      s += (period[i].phase < int'(HALF)) ? period[i].data : -period[i].data;
    return AW'(s);
  endfunction

  // Period-level view: a pulse closes the previous period (if one was fully
  // observed) and opens a new one; samples before the first pulse are dropped.
  always @(posedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      period.delete();
      primed = 1'b0;
    end else if (en_i) begin
      if (pulse_i) begin
        if (primed) exp_q.push_back(period_sum());
        period.delete();
        primed = 1'b1;
      end
      if (primed) period.push_back('{int'(phase_i), int'(data_i)});
    end
  end

  // ---------------- monitor ----------------
  // The queue holds every result not yet consumed. Two pending entries after a
  // dump mean the older one was overwritten, which must raise overrun_o.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (overrun_o) begin
        check("overrun_legit", longint'(exp_q.size() >= 2), 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        check("overrun_missing", longint'(exp_q.size() >= 2), 0);
      end
      check("valid_o", longint'(valid_o), longint'(exp_q.size() > 0));
      if (valid_o && exp_q.size() > 0) check("acc_o", acc_o, exp_q[0]);
      if (valid_o && ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  int cnt;
  int data_mode;  // 0: 100, 1: phase index, 2: -32768, 3: random

  // rdy_mode: 0/1 constant, 2: ready only on the pulse sample, 3: random
  task automatic step(input logic en, input int rdy_mode);
    @(posedge clk);
    #1;
    if (en_i) cnt = (cnt == UPTO) ? 0 : cnt + 1;
    en_i    = en;
    phase_i = PW'(cnt);
    pulse_i = (cnt == 0);
    case (rdy_mode)
      0:       ready_i = 1'b0;
      1:       ready_i = 1'b1;
      2:       ready_i = (cnt == 0);
      default: ready_i = 1'($urandom_range(0, 1));
    endcase
    case (data_mode)
      0:       data_i = 16'sd100;
      1:       data_i = DW'(cnt);
      2:       data_i = 16'sh8000;
      default: data_i = DW'($urandom);
    endcase
  endtask

  task automatic run_until_valid(input string name, input int rdy_mode,
                                 input bit rand_en, output int steps);
    bit   found = 1'b0;
    logic e;
    steps = 0;
    while (!found && steps < 200) begin
      e = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      step(e, rdy_mode);
      steps++;
      @(negedge clk);
      if (valid_o) found = 1'b1;
    end
    check({name, "_found"}, longint'(found), 1);
  endtask

  int steps;
  int ovr;

  initial begin
    rst_i     = 1'b1;
    en_i      = 1'b0;
    ready_i   = 1'b1;
    data_i    = '0;
    phase_i   = '0;
    pulse_i   = 1'b0;
    cnt       = 0;
    data_mode = 0;

    repeat (3) step(1'b0, 1);
    @(negedge clk);
    check("reset_acc", acc_o, 0);
    check("reset_valid", longint'(valid_o), 0);
    check("reset_overrun", longint'(overrun_o), 0);

    // Priming: released at phase 3, the partial period must be discarded.
    cnt   = 3;
    rst_i = 1'b0;
    run_until_valid("prime", 1, 1'b0, steps);
    check("prime_latency", steps, 21);
    check("prime_result", acc_o, -100);

    // Steady period: one result every 11 samples.
    repeat (2) begin
      run_until_valid("steady", 1, 1'b0, steps);
      check("steady_interval", steps, 11);
      check("steady_result", acc_o, -100);
    end

    // Backpressure across two dumps.
    run_until_valid("bp_first", 0, 1'b0, steps);
    ovr = 0;
    repeat (11) begin
      step(1'b1, 0);
      @(negedge clk);
      if (overrun_o) ovr++;
    end
    check("bp_overrun_count", ovr, 1);
    check("bp_valid_held", longint'(valid_o), 1);
    step(1'b1, 1);
    @(negedge clk);
    check("bp_valid_before_accept", longint'(valid_o), 1);
    step(1'b1, 0);
    @(negedge clk);
    check("bp_valid_after_accept", longint'(valid_o), 0);

    // Simultaneous accept + dump: ready only on pulse samples.
    ovr = 0;
    repeat (45) begin
      step(1'b1, 2);
      @(negedge clk);
      if (overrun_o) ovr++;
    end
    check("accdump_overrun_count", ovr, 0);
    check("accdump_valid", longint'(valid_o), 1);
    repeat (12) step(1'b1, 1);

    // Enable gaps with data = phase index; first result may mix modes.
    data_mode = 1;
    run_until_valid("gap_warm", 1, 1'b1, steps);
    repeat (2) begin
      run_until_valid("gap", 1, 1'b1, steps);
      check("gap_result", acc_o, -35);
    end

    // Extremes: most-negative sample everywhere.
    data_mode = 2;
    run_until_valid("ext_warm", 1, 1'b0, steps);
    run_until_valid("ext", 1, 1'b0, steps);
    check("ext_result", acc_o, 32768);

    // Reset mid-period with a result pending.
    repeat (4) step(1'b1, 0);
    rst_i = 1'b1;
    step(1'b1, 0);
    @(negedge clk);
    check("midrst_acc", acc_o, 0);
    check("midrst_valid", longint'(valid_o), 0);
    check("midrst_overrun", longint'(overrun_o), 0);
    rst_i = 1'b0;
    run_until_valid("reprime", 1, 1'b0, steps);
    check("reprime_min_latency", longint'(steps >= 12), 1);
    check("reprime_result", acc_o, 32768);

    // Random data, enable and ready.
    data_mode = 3;
    repeat (800) step(1'($urandom_range(0, 1)), 3);
    repeat (30) step(1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule : tb_phctrl_dump_accum
